// File: rtl/prog_run_ctrl_pkg.sv
// Shared run-sequencer types and default widths for the controller and its bench.
package prog_run_pkg;

   typedef enum logic [2:0] {IDLE, INIT, RUN, DONE, TOUT} run_state_t;

   localparam int CW_DEF       = 16;
   localparam int INIT_CYC_DEF = 2;

endpackage

// File: rtl/prog_run_ctrl_if.sv
// Bench <-> run sequencer handshake plus the core control lines it drives.
interface prog_run_ctrl_if #(
   parameter int CW = 16
) ();

   logic          req;
   logic          abort;
   logic          core_done;
   logic          core_rst;
   logic          core_en;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycle_cnt;

   modport master (
      output req, abort, core_done,
      input  core_rst, core_en, busy, done, timeout, cycle_cnt
   );

   modport slave (
      input  req, abort, core_done,
      output core_rst, core_en, busy, done, timeout, cycle_cnt
   );

endinterface

// File: rtl/prog_run_ctrl_sat_counter.sv
// Saturating up-counter: clr wins over en, holds at all-ones; q updates one edge after en.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         at_max
);

   assign at_max = &q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && !at_max) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/prog_run_ctrl.sv
// Run sequencer: req -> INIT (core held in reset) -> RUN (core enabled, cycles counted) -> DONE/TOUT.
// core_en rises INIT_CYC+1 edges after req; done follows core_done by one edge; no backpressure, outputs decode state only.
module prog_run_ctrl
   import prog_run_pkg::*;
#(
   parameter int            CW       = CW_DEF,
   parameter int            INIT_CYC = INIT_CYC_DEF,
   parameter logic [CW-1:0] MAX_CYC  = {CW{1'b1}}
) (
   input  logic           clk,
   input  logic           reset,
   prog_run_ctrl_if.slave bus
);

   localparam int            IW      = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);
   localparam logic [CW-1:0] TOUT_AT   = MAX_CYC - CW'(1);

   run_state_t    state;
   run_state_t    state_nxt;
   logic [IW-1:0] init_cnt;
   logic [CW-1:0] cyc_q;
   logic          cyc_at_max;
   logic          cyc_clr;

   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (bus.req) state_nxt = INIT;
            INIT: begin
               if (!bus.req)                   state_nxt = IDLE;
               else if (init_cnt == INIT_LAST) state_nxt = RUN;
            end
            // core_done is checked first so a finish on the last budgeted cycle is not a timeout
            RUN: begin
               if (bus.core_done)                           state_nxt = DONE;
               else if (cyc_q == TOUT_AT || cyc_at_max)     state_nxt = TOUT;
            end
            DONE, TOUT: if (!bus.req) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT) init_cnt <= init_cnt + IW'(1);
         else               init_cnt <= '0;
      end
   end

   assign cyc_clr = (state == IDLE) && (state_nxt == INIT);

   sat_counter #(.W(CW)) u_cyc_cnt (
      .clk    (clk),
      .reset  (reset),
      .clr    (cyc_clr),
      .en     (state == RUN),
      .q      (cyc_q),
      .at_max (cyc_at_max)
   );

   assign bus.core_rst  = (state == IDLE) || (state == INIT);
   assign bus.core_en   = (state == RUN);
   assign bus.busy      = (state == INIT) || (state == RUN);
   assign bus.done      = (state == DONE) || (state == TOUT);
   assign bus.timeout   = (state == TOUT);
   assign bus.cycle_cnt = cyc_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
module tb_prog_run_ctrl;
   import prog_run_pkg::*;

   localparam int IC    = INIT_CYC_DEF;
   localparam int CW    = CW_DEF;
   localparam int MAX_A = 16;
   localparam int MAX_B = 65535;

   typedef struct packed {
      logic          core_rst;
      logic          core_en;
      logic          busy;
      logic          done;
      logic          timeout;
      logic [CW-1:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   prog_run_ctrl_if #(.CW(CW)) ifa ();
   prog_run_ctrl_if #(.CW(CW)) ifb ();

   prog_run_ctrl #(.CW(CW), .INIT_CYC(IC), .MAX_CYC(16'd16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   prog_run_ctrl #(.CW(CW), .INIT_CYC(IC)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   obs_t          qa[$];
   obs_t          qb[$];
   int            total = 0;
   int            bad   = 0;
   logic [CW-1:0] prev_a = '0;
   logic [CW-1:0] prev_b = '0;

   function automatic obs_t mk(logic r, logic e, logic b, logic d, logic t, int c);
      obs_t o;
      o.core_rst = r; o.core_en = e; o.busy = b; o.done = d; o.timeout = t;
      o.cnt = CW'(c);
      return o;
   endfunction

   // Expected outputs in the interval after edge i of a run, ignoring abort/reset.
   // k: core_done in RUN cycle k; d: first interval with req low; prev: count left by the previous run.
   function automatic obs_t plain(int i, int mx, int k, int d, logic [CW-1:0] prev);
      int end_r, e, last;
      bit tout;
      tout  = (k > mx);
      end_r = tout ? mx : k;
      if (i == 0) return mk(1, 0, 0, 0, 0, int'(prev));
      if (d <= IC) begin
         if (i <= d) return mk(1, 0, 1, 0, 0, 0);
         return mk(1, 0, 0, 0, 0, 0);
      end
      if (i <= IC) return mk(1, 0, 1, 0, 0, 0);
      if (i <= IC + end_r) return mk(0, 1, 1, 0, 0, i - IC - 1);
      e    = IC + end_r + 1;
      last = (e > d) ? e : d;
      if (i <= last) return mk(0, 0, 0, 1, tout, end_r);
      return mk(1, 0, 0, 0, 0, end_r);
   endfunction

   function automatic obs_t model(int i, int mx, int k, int d, int a, int x, logic [CW-1:0] prev);
      obs_t o;
      if (x > 0 && i >= x) return mk(1, 0, 0, 0, 0, 0);
      if (a > 0 && i > a) begin
         o = plain(a + 1, mx, k, d, prev);
         return mk(1, 0, 0, 0, 0, int'(o.cnt));
      end
      return plain(i, mx, k, d, prev);
   endfunction

   task automatic chk(string name, obs_t g, obs_t e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s t=%0t: got rst=%b en=%b busy=%b done=%b tout=%b cnt=%0d, expected rst=%b en=%b busy=%b done=%b tout=%b cnt=%0d",
                  name, $time, g.core_rst, g.core_en, g.busy, g.done, g.timeout, g.cnt,
                  e.core_rst, e.core_en, e.busy, e.done, e.timeout, e.cnt);
      end
   endtask

   always @(negedge clk) begin : monitor
      obs_t ga, gb;
      ga = {ifa.core_rst, ifa.core_en, ifa.busy, ifa.done, ifa.timeout, ifa.cycle_cnt};
      gb = {ifb.core_rst, ifb.core_en, ifb.busy, ifb.done, ifb.timeout, ifb.cycle_cnt};
      if (qa.size() > 0) chk("dut_a", ga, qa.pop_front());
      if (qb.size() > 0) chk("dut_b", gb, qb.pop_front());
   end

   task automatic drive(logic r, logic ab, logic cd);
      ifa.req = r; ifa.abort = ab; ifa.core_done = cd;
      ifb.req = r; ifb.abort = ab; ifb.core_done = cd;
   endtask

   // One run; a = abort interval, x = reset interval (0 = none). req is dropped by the abort/reset.
   task automatic scenario(int k, int d_in, int a, int x, int len, bit noise);
      int   d;
      logic cd;
      obs_t oa;
      d = d_in;
      if (a > 0 && a < d) d = a;
      if (x > 0 && x < d) d = x;
      for (int i = 0; i < len; i++) begin
         @(posedge clk);
         #1;
         cd = (i == IC + k);
         if (noise && (i <= IC || i > IC + k) && $urandom_range(0, 3) == 0) cd = 1'b1;
         if (x > 0 && i == x)     reset = 1'b0;
         if (x > 0 && i == x + 2) reset = 1'b1;
         drive(i < d, (a > 0 && i == a), cd);
         qa.push_back(model(i, MAX_A, k, d, a, x, prev_a));
         qb.push_back(model(i, MAX_B, k, d, a, x, prev_b));
      end
      oa     = model(len - 1, MAX_A, k, d, a, x, prev_a);
      prev_a = oa.cnt;
      oa     = model(len - 1, MAX_B, k, d, a, x, prev_b);
      prev_b = oa.cnt;
   endtask

   function automatic int run_len(int k, int d);
      return ((IC + k + 1 > d) ? IC + k + 1 : d) + 3;
   endfunction

   initial begin
      int k, d, a, x, len, typ;
      reset = 1'b0;
      drive(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         qa.push_back(mk(1, 0, 0, 0, 0, 0));
         qb.push_back(mk(1, 0, 0, 0, 0, 0));
      end
      reset = 1'b1;

      // done at RUN cycle 40 (dut_a times out at 16), req held 10 cycles after DONE
      scenario(40, IC + 41 + 10, 0, 0, run_len(40, IC + 51), 1'b0);
      // done coincides with the last budgeted cycle of dut_a
      scenario(16, IC + 19, 0, 0, run_len(16, IC + 19), 1'b0);
      // one past the budget on dut_a
      scenario(17, IC + 20, 0, 0, run_len(17, IC + 20), 1'b1);
      // async reset in RUN cycle 7
      scenario(20, IC + 25, 0, IC + 7, run_len(20, IC + 25), 1'b0);
      // abort in RUN cycle 7, count held into the next run
      scenario(20, IC + 25, IC + 7, 0, run_len(20, IC + 25), 1'b0);
      // cancel during INIT, then a plain short run
      scenario(10, IC, 0, 0, run_len(10, IC), 1'b0);
      scenario(5, IC + 6, 0, 0, run_len(5, IC + 6), 1'b0);
      // req dropped during RUN is ignored
      scenario(12, IC + 4, 0, 0, run_len(12, IC + 4), 1'b0);

      for (int n = 0; n < 40; n++) begin
         k   = $urandom_range(1, 60);
         typ = $urandom_range(0, 7);
         if (typ == 0)      d = $urandom_range(1, IC);
         else if (typ == 1) d = $urandom_range(IC + 1, IC + k);
         else               d = IC + k + 1 + $urandom_range(0, 12);
         len = run_len(k, d) + $urandom_range(0, 2);
         a = 0;
         x = 0;
         if ($urandom_range(0, 5) == 0)      a = $urandom_range(1, len - 3);
         else if ($urandom_range(0, 7) == 0) x = $urandom_range(1, len - 4);
         scenario(k, d, a, x, len, 1'b1);
      end

      repeat (3) @(posedge clk);
      total++;
      if (qa.size() + qb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, expected 0", qa.size() + qb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
